// File: rtl/dp_ram_arb_pkg.sv
// dp_ram_arb_pkg: shared sizing helpers and response tag type for dp_ram_be_arbiter
package dp_ram_arb_pkg;
  localparam int MAX_NREQ = 8;
  typedef logic [$clog2(MAX_NREQ)-1:0] rsp_tag_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin search from ptr upward; gnt_idx is the candidate even when en blocks the grant
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic hit;
  int   j;
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        hit     = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end
  assign any = hit & en;
  assign gnt = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/dp_ram_be_arbiter.sv
// dp_ram_be_arbiter: round-robin sharing of a byte-enable dual-port RAM among NREQ writers and readers
module dp_ram_be_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 2880,
  parameter int NREQ  = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int IW   = clog2_min1(NREQ),
  localparam int BW   = DW / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   wr_valid,
  output logic [NREQ-1:0]   wr_ready,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  input  logic [NREQ*BW-1:0] wr_be,
  input  logic [NREQ-1:0]   rd_valid,
  output logic [NREQ-1:0]   rd_ready,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [DW-1:0]     rsp_data,
  output logic              ram_we,
  output logic [AW-1:0]     ram_wa,
  output logic [DW-1:0]     ram_wd,
  output logic [BW-1:0]     ram_wbe,
  output logic              ram_re,
  output logic [AW-1:0]     ram_ra,
  input  logic [DW-1:0]     ram_rd
);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
  logic [IW-1:0] wr_ptr, rd_ptr, wg, rc;
  logic          wr_any, rd_any, hazard;
  rr_arb #(.N(NREQ), .IW(IW)) u_wr (
    .req(wr_valid), .ptr(wr_ptr), .en(1'b1),
    .gnt(wr_ready), .gnt_idx(wg), .any(wr_any)
  );
  // A read colliding with this cycle's write waits one cycle so it sees the written data
  assign hazard = wr_any && (rd_addr[wg*0 + rc*AW +: AW] == wr_addr[wg*AW +: AW]);
  rr_arb #(.N(NREQ), .IW(IW)) u_rd (
    .req(rd_valid), .ptr(rd_ptr), .en(!hazard),
    .gnt(rd_ready), .gnt_idx(rc), .any(rd_any)
  );
  assign ram_we   = wr_any;
  assign ram_wa   = wr_any ? wr_addr[wg*AW +: AW] : '0;
  assign ram_wd   = wr_any ? wr_data[wg*DW +: DW] : '0;
  assign ram_wbe  = wr_any ? wr_be[wg*BW +: BW] : '0;
  assign ram_re   = rd_any;
  assign ram_ra   = rd_any ? rd_addr[rc*AW +: AW] : '0;
  assign rsp_data = ram_rd;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (wr_any) wr_ptr <= (wg == LAST) ? '0 : wg + 1'b1;
      if (rd_any) rd_ptr <= (rc == LAST) ? '0 : rc + 1'b1;
      if (rd_any) rsp_id <= rc;
      rsp_valid <= rd_any;
    end
endmodule
